// File: rtl/lifting_mac_if.sv
// Operand/result bundle for the lifting MAC: valid-tagged operands in, valid-tagged result out.
interface lifting_mac_if #(
  parameter int size = 32
);
  logic            vi;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic [size-1:0] c;
  logic [2:0]      cons;
  logic [size-1:0] d;
  logic            vo;

  modport master (output vi, a, b, c, cons, input d, vo);
  modport slave  (input vi, a, b, c, cons, output d, vo);
endinterface

// File: rtl/lifting_mac.sv
// Two-stage lifting step d = sat(a + round(C[cons] * (b + c))) for the 9/7 DWT datapath.
module lifting_mac #(
  parameter int size = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  lifting_mac_if.slave mac
);

  localparam int PW = size + 19;
  localparam int TW = size + 4;

  // The coefficient ROM carries its own 16 fractional bits, so the data format
  // only needs FRAC to leave at least the sign bit as integer part.
  if (FRAC >= size) begin : g_frac_leaves_no_integer_bits
  end

  logic signed [size:0]   s1_q, s1_d;
  logic signed [size-1:0] a1_q, a1_d;
  logic signed [17:0]     coef1_q, coef1_d;
  logic                   v1_q, v1_d;
  logic [size-1:0]        d_q, d_d;
  logic                   vo_q, vo_d;

  logic signed [17:0]     coef_sel;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_rnd;
  logic signed [PW-1:0]   prod_shr;
  logic signed [TW-1:0]   sum_full;
  logic [size-1:0]        sum_sat;

  always_comb begin
    coef_sel = '0;
    case (mac.cons)
      3'd0:    coef_sel = -18'sd103949;
      3'd1:    coef_sel = -18'sd3472;
      3'd2:    coef_sel = 18'sd57862;
      3'd3:    coef_sel = 18'sd29066;
      3'd4:    coef_sel = 18'sd75340;
      3'd5:    coef_sel = 18'sd57007;
      default: coef_sel = '0;
    endcase
  end

  always_comb begin
    s1_d    = s1_q;
    a1_d    = a1_q;
    coef1_d = coef1_q;
    v1_d    = mac.vi;
    if (mac.vi) begin
      s1_d    = (size+1)'($signed(mac.b)) + (size+1)'($signed(mac.c));
      a1_d    = $signed(mac.a);
      coef1_d = coef_sel;
    end
  end

  // Round half toward +inf, then saturate whenever the guard bits disagree with the sign.
  always_comb begin
    prod     = PW'(s1_q) * PW'(coef1_q);
    prod_rnd = prod + PW'(32768);
    prod_shr = prod_rnd >>> 16;
    sum_full = TW'(a1_q) + TW'(prod_shr);
    if (sum_full[TW-1:size-1] == {(TW-size+1){sum_full[TW-1]}}) begin
      sum_sat = sum_full[size-1:0];
    end else begin
      sum_sat = {sum_full[TW-1], {(size-1){~sum_full[TW-1]}}};
    end
  end

  always_comb begin
    d_d  = v1_q ? sum_sat : d_q;
    vo_d = v1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      a1_q    <= '0;
      coef1_q <= '0;
      v1_q    <= 1'b0;
      d_q     <= '0;
      vo_q    <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      a1_q    <= a1_d;
      coef1_q <= coef1_d;
      v1_q    <= v1_d;
      d_q     <= d_d;
      vo_q    <= vo_d;
    end
  end

  assign mac.d  = d_q;
  assign mac.vo = vo_q;

endmodule

// File: tb/tb_lifting_mac.sv
// Directed-vector bench for lifting_mac with hand-computed results.
module tb_lifting_mac;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lifting_mac_if #(.size(32)) mac_if ();

  lifting_mac #(.size(32), .FRAC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mac   (mac_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [2:0] cons);
    mac_if.vi   = 1'b1;
    mac_if.a    = a;
    mac_if.b    = b;
    mac_if.c    = c;
    mac_if.cons = cons;
  endtask

  task automatic idle();
    mac_if.vi   = 1'b0;
    mac_if.a    = 32'hDEAD_BEEF;
    mac_if.b    = 32'h5555_AAAA;
    mac_if.c    = 32'h1234_0000;
    mac_if.cons = 3'd2;
  endtask

  // One operand set, result checked two edges later; vo must still be low after one edge.
  task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [2:0] cons,
                          input logic [31:0] exp);
    @(negedge clk);
    drive(a, b, c, cons);
    @(negedge clk);
    idle();
    check({tag, "_vo_lat1"}, {31'd0, mac_if.vo}, 32'd0);
    @(negedge clk);
    check({tag, "_vo"}, {31'd0, mac_if.vo}, 32'd1);
    check({tag, "_d"}, mac_if.d, exp);
  endtask

  logic [31:0] tp_exp [4];
  logic [2:0]  cons_v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    check("reset_d", mac_if.d, 32'd0);
    check("reset_vo", {31'd0, mac_if.vo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    one_shot("delta", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 3'd3, 32'h0001_E314);
    one_shot("alpha", 32'h0, 32'h0001_0000, 32'h0001_0000, 3'd0, 32'hFFFC_D3E6);
    one_shot("round_pos", 32'h0, 32'h1, 32'h0, 3'd4, 32'h0000_0001);
    one_shot("round_neg", 32'h0, 32'hFFFF_FFFF, 32'h0, 3'd4, 32'hFFFF_FFFF);
    one_shot("inv_k", 32'h0, 32'h0002_0000, 32'h0, 3'd5, 32'h0001_BD5E);
    one_shot("pass6", 32'h1234_5678, 32'hCAFE_F00D, 32'h7777_0001, 3'd6, 32'h1234_5678);
    one_shot("pass7", 32'h8765_4321, 32'h0101_0101, 32'hFFFF_0000, 3'd7, 32'h8765_4321);
    one_shot("sat_pos", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 3'd4, 32'h7FFF_FFFF);
    one_shot("sat_neg", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'd4, 32'h8000_0000);

    // Result holds while vo is low.
    repeat (3) @(negedge clk);
    check("hold_d", mac_if.d, 32'h8000_0000);
    check("hold_vo", {31'd0, mac_if.vo}, 32'd0);

    tp_exp[0] = 32'hFFFC_D3E6;
    tp_exp[1] = 32'hFFFF_E4E0;
    tp_exp[2] = 32'h0001_C40C;
    tp_exp[3] = 32'h0000_E314;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 5) begin
        check($sformatf("tp_vo%0d", i), {31'd0, mac_if.vo}, 32'd1);
        check($sformatf("tp_d%0d", i), mac_if.d, tp_exp[i-2]);
      end else begin
        check($sformatf("tp_vo%0d", i), {31'd0, mac_if.vo}, 32'd0);
      end
      if (i < 4) begin
        cons_v = 3'(i);
        drive(32'h0, 32'h0001_0000, 32'h0001_0000, cons_v);
      end else begin
        idle();
      end
    end

    // Reset between edges while a sample sits in stage 1.
    @(negedge clk);
    drive(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 3'd3);
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_d", mac_if.d, 32'd0);
    check("mid_rst_vo", {31'd0, mac_if.vo}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_vo%0d", i), {31'd0, mac_if.vo}, 32'd0);
    end
    check("post_rst_d", mac_if.d, 32'd0);

    one_shot("after_rst", 32'h0, 32'h0001_0000, 32'h0001_0000, 3'd1, 32'hFFFF_E4E0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
